// File: rtl/idecode_stage_pkg.sv
// Shared definitions for the instruction decode stage: field ordering inside
// an instruction word and width derivations used by this and later stages.
package idecode_stage_pkg;

  localparam int unsigned NUM_FIELDS = 4;

  // Field slot index: slot i occupies bits [i*FW +: FW] of the instruction.
  typedef enum logic [1:0] {
    FLD_DEST = 2'd0,
    FLD_Q1   = 2'd1,
    FLD_Q0   = 2'd2,
    FLD_OP   = 2'd3
  } field_e;

  function automatic int unsigned iw_of(input int unsigned fw);
    return NUM_FIELDS * fw;
  endfunction

  // Packed bundle: {instr, imm, is_imm, illegal}
  function automatic int unsigned bundle_w_of(input int unsigned fw);
    return iw_of(fw) + 2 * fw + 2;
  endfunction

endpackage

// File: rtl/idecode_skid.sv
// Generic WIDTH-bit valid/ready register stage with a one-entry skid slot;
// ready depends only on registered state and reset, never on downstream ready.
module idecode_skid
  import idecode_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_in_fire;
  logic             w_out_free;

  assign o_in_ready  = ~r_skid_valid & ~rst;
  assign w_in_fire   = i_in_valid & o_in_ready;
  assign w_out_free  = ~r_out_valid | i_out_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (i_flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      // Skid entry is older than anything offered now (ready was low), so it goes first.
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_in_fire;
        if (w_in_fire) begin
          r_out_data <= i_in_data;
        end
      end
    end else if (w_in_fire) begin
      r_skid_data  <= i_in_data;
      r_skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/idecode_stage.sv
// Registered instruction decode stage: splits words into OP/Q0/Q1/DEST and
// classifies them; optional delivery counters under IDECODE_PERF_CNT_EN.
module idecode_stage
  import idecode_stage_pkg::*;
#(
  parameter int unsigned           FW              = 4,
  parameter int unsigned           IMM_OP_BASE     = 8,
  parameter logic [(1<<FW)-1:0]    OP_ILLEGAL_MASK = 16'h8000,
  parameter int unsigned           CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*FW-1:0]   in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FW-1:0]     out_op,
  output logic [FW-1:0]     out_q0,
  output logic [FW-1:0]     out_q1,
  output logic [FW-1:0]     out_dest,
  output logic [2*FW-1:0]   out_imm,
  output logic              out_is_imm,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  cnt_instr,
  output logic [CNT_W-1:0]  cnt_illegal
);

  localparam int unsigned IW = iw_of(FW);
  localparam int unsigned BW = bundle_w_of(FW);

  logic [FW-1:0]   w_field [NUM_FIELDS];
  logic [FW-1:0]   w_op;
  logic            w_is_imm;
  logic            w_illegal;
  logic [2*FW-1:0] w_imm;
  logic [BW-1:0]   w_dec;
  logic [BW-1:0]   w_out_bundle;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      assign w_field[gi] = in_instr[gi*FW +: FW];
    end
  endgenerate

  assign w_op      = w_field[FLD_OP];
  assign w_is_imm  = (32'(w_op) >= IMM_OP_BASE);
  assign w_illegal = OP_ILLEGAL_MASK[w_op];
  assign w_imm     = w_is_imm ? {w_field[FLD_Q0], w_field[FLD_Q1]} : '0;
  assign w_dec     = {in_instr[IW-1:0], w_imm, w_is_imm, w_illegal};

  idecode_skid #(
    .WIDTH (BW)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (w_dec),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (w_out_bundle)
  );

  assign {out_op, out_q0, out_q1, out_dest, out_imm, out_is_imm, out_illegal} = w_out_bundle;

`ifdef IDECODE_PERF_CNT_EN
  logic [CNT_W-1:0] r_cnt_instr;
  logic [CNT_W-1:0] r_cnt_illegal;

  // Flush does not cancel a delivery that completes in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_instr   <= '0;
      r_cnt_illegal <= '0;
    end else if (out_valid && out_ready) begin
      r_cnt_instr <= r_cnt_instr + 1'b1;
      if (out_illegal) begin
        r_cnt_illegal <= r_cnt_illegal + 1'b1;
      end
    end
  end

  assign cnt_instr   = r_cnt_instr;
  assign cnt_illegal = r_cnt_illegal;
`else
  assign cnt_instr   = '0;
  assign cnt_illegal = '0;
`endif

endmodule

// File: tb/tb_idecode_stage.sv
// Self-checking bench for idecode_stage: directed + random stimulus against a
// queue-based model of a two-deep in-order decode stage.
module tb_idecode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op, out_q0, out_q1, out_dest;
  logic [7:0]  out_imm;
  logic        out_is_imm;
  logic        out_illegal;
  logic [3:0]  cnt_instr;
  logic [3:0]  cnt_illegal;

  always #5 clk = ~clk;

  idecode_stage #(
    .FW              (4),
    .IMM_OP_BASE     (8),
    .OP_ILLEGAL_MASK (16'h8000),
    .CNT_W           (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_q0      (out_q0),
    .out_q1      (out_q1),
    .out_dest    (out_dest),
    .out_imm     (out_imm),
    .out_is_imm  (out_is_imm),
    .out_illegal (out_illegal),
    .cnt_instr   (cnt_instr),
    .cnt_illegal (cnt_illegal)
  );

  // Reference model: words held by the stage, oldest first (capacity 2).
  logic [15:0] mdl_q[$];
  bit          mdl_zero_fields = 1'b1;
  logic [3:0]  mdl_cnt_instr   = '0;
  logic [3:0]  mdl_cnt_illegal = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected decode computed arithmetically from the word.
  task automatic check_fields(input logic [15:0] w);
    int x, op, q0, q1, dest, is_imm, imm, illegal;
    x       = int'(w);
    op      = (x / 4096) % 16;
    q0      = (x / 256) % 16;
    q1      = (x / 16) % 16;
    dest    = x % 16;
    is_imm  = (op >= 8) ? 1 : 0;
    imm     = is_imm ? (q0 * 16 + q1) : 0;
    illegal = (op == 15) ? 1 : 0;
    chk("out_op", 32'(out_op), op);
    chk("out_q0", 32'(out_q0), q0);
    chk("out_q1", 32'(out_q1), q1);
    chk("out_dest", 32'(out_dest), dest);
    chk("out_imm", 32'(out_imm), imm);
    chk("out_is_imm", 32'(out_is_imm), is_imm);
    chk("out_illegal", 32'(out_illegal), illegal);
  endtask

  // One clock: drive inputs, check outputs at the falling edge, advance model.
  task automatic step(input logic r, input logic v, input logic [15:0] w,
                      input logic ordy, input logic fl, output bit accepted);
    bit exp_rdy, exp_vld, in_fire, out_fire;
    logic [15:0] head;
    rst = r; in_valid = v; in_instr = w; out_ready = ordy; flush = fl;
    @(negedge clk);
    exp_rdy = (mdl_q.size() < 2) && !r;
    exp_vld = (mdl_q.size() > 0);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_vld));
    if (exp_vld) check_fields(mdl_q[0]);
    else if (mdl_zero_fields) check_fields(16'h0000);
`ifdef IDECODE_PERF_CNT_EN
    chk("cnt_instr", 32'(cnt_instr), 32'(mdl_cnt_instr));
    chk("cnt_illegal", 32'(cnt_illegal), 32'(mdl_cnt_illegal));
`else
    chk("cnt_instr", 32'(cnt_instr), 0);
    chk("cnt_illegal", 32'(cnt_illegal), 0);
`endif
    in_fire  = v && exp_rdy;
    out_fire = exp_vld && ordy;
    accepted = in_fire && !fl && !r;
    @(posedge clk);
    #1;
    if (r) begin
      mdl_q.delete();
      mdl_zero_fields = 1'b1;
      mdl_cnt_instr   = '0;
      mdl_cnt_illegal = '0;
    end else begin
      if (out_fire) begin
        head = mdl_q.pop_front();
        mdl_cnt_instr = mdl_cnt_instr + 4'd1;
        if (head[15:12] == 4'hF) mdl_cnt_illegal = mdl_cnt_illegal + 4'd1;
      end
      if (fl) mdl_q.delete();
      else if (in_fire) begin
        mdl_q.push_back(w);
        mdl_zero_fields = 1'b0;
      end
    end
  endtask

  initial begin
    bit          acc;
    int          k;
    logic [15:0] w;
    logic [15:0] bp [4];
    logic [15:0] dir [4];

    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_instr = 16'h1234; out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset held three cycles with an offered word.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0, acc);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, acc);

    // Directed decode cases, one per cycle.
    dir[0] = 16'h0000; dir[1] = 16'hABCD; dir[2] = 16'hAE13; dir[3] = 16'hFFE1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, dir[i], 1'b1, 1'b0, acc);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, acc);

    // Stream of 8 words at full rate.
    k = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 16'($urandom_range(0, 65535)), 1'b1, 1'b0, acc);
      if (acc) k++;
    end
    chk("stream_accepted", k, 8);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, acc);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, acc);

    // Back-pressure: 3 words offered while the consumer stalls for 4 cycles.
    bp[0] = 16'h1111; bp[1] = 16'h9AB2; bp[2] = 16'hF3C4; bp[3] = 16'h0000;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, bp[k], 1'b0, 1'b0, acc);
      if (acc) k++;
    end
    chk("bp_accepted_stalled", k, 2);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, k < 3, bp[k], 1'b1, 1'b0, acc);
      if (acc) k++;
    end
    chk("bp_accepted_release", k, 3);

    // Flush with skid full and a word offered; then flush during a delivery.
    step(1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b1, acc);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, acc);
    step(1'b0, 1'b1, 16'h4444, 1'b1, 1'b0, acc);
    step(1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b1, acc);
    chk("flush_drop", 32'(acc), 0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, acc);

    // Reset in the middle of a stall.
    step(1'b0, 1'b1, 16'h8765, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 16'hC001, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 16'h7777, 1'b0, 1'b0, acc);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, acc);

    // Randomized traffic with occasional flush and reset.
    w = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 127) == 0), ($urandom_range(0, 3) != 0), w,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0), acc);
      if (acc || $urandom_range(0, 3) == 0) begin
        w = 16'($urandom_range(0, 65535));
        if ($urandom_range(0, 3) == 0) w[15:12] = 4'hF;
      end
    end

    // Counter wrap: 17 deliveries, two of them illegal.
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, acc);
    for (int i = 0; i < 17; i++) begin
      w = 16'($urandom_range(0, 65535));
      w[15:12] = 4'($urandom_range(0, 14));
      if (i == 3 || i == 9) w[15:12] = 4'hF;
      step(1'b0, 1'b1, w, 1'b1, 1'b0, acc);
    end
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, acc);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, acc);
    @(negedge clk);
`ifdef IDECODE_PERF_CNT_EN
    chk("cnt17_instr", 32'(cnt_instr), 1);
    chk("cnt17_illegal", 32'(cnt_illegal), 2);
`else
    chk("cnt17_instr", 32'(cnt_instr), 0);
    chk("cnt17_illegal", 32'(cnt_illegal), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
